// File: rtl/ast_trace_streamer.sv
// Debug trace streamer: buffers 12-char ASCII instruction strings and serializes
// them MSB-first onto a valid/ready byte stream, optionally ending each with CR LF.
module ast_trace_streamer #(
  parameter int DEPTH     = 4,
  parameter bit TRAIL_EOL = 1'b1
) (
  input  logic                     Clock_pin,
  input  logic                     Reset_pin,
  input  logic [95:0]              ICis,
  input  logic                     ICis_valid,
  output logic [7:0]               Tx_data,
  output logic                     Tx_valid,
  input  logic                     Tx_ready,
  output logic [$clog2(DEPTH):0]   Fifo_level,
  output logic [7:0]               Overflow_cnt,
  output logic                     Busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, CR, LF} state_t;

  state_t        state;
  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [87:0]   sr;
  logic [3:0]    idx;
  logic          full, pop, push, drop, advance;

  assign full    = (Fifo_level == (AW+1)'(DEPTH));
  assign pop     = (state == LOAD);
  assign push    = ICis_valid && (!full || pop);
  assign drop    = ICis_valid && full && !pop;
  // A NUL slot has Tx_valid low, so it advances without waiting for the sink.
  assign advance = !Tx_valid || Tx_ready;
  assign Busy    = (state != IDLE) || (Fifo_level != '0);

  always_ff @(posedge Clock_pin) begin
    if (push) mem[wr_ptr] <= ICis;
  end

  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Fifo_level   <= '0;
      Overflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Fifo_level <= Fifo_level + 1'b1;
        2'b01:   Fifo_level <= Fifo_level - 1'b1;
        default: ;
      endcase
      if (drop && Overflow_cnt != 8'hFF) Overflow_cnt <= Overflow_cnt + 1'b1;
    end
  end

  // Tx_data/Tx_valid are computed one step ahead so they are pure registers.
  always_ff @(posedge Clock_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      state    <= IDLE;
      sr       <= '0;
      idx      <= '0;
      Tx_data  <= '0;
      Tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Fifo_level != '0) state <= LOAD;
        LOAD: begin
          sr       <= mem[rd_ptr][87:0];
          idx      <= '0;
          Tx_data  <= mem[rd_ptr][95:88];
          Tx_valid <= |mem[rd_ptr][95:88];
          state    <= SEND;
        end
        SEND: if (advance) begin
          if (idx == 4'd11) begin
            if (TRAIL_EOL) begin
              state    <= CR;
              Tx_data  <= 8'h0D;
              Tx_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              Tx_data  <= '0;
              Tx_valid <= 1'b0;
            end
          end else begin
            idx      <= idx + 1'b1;
            sr       <= {sr[79:0], 8'h00};
            Tx_data  <= sr[87:80];
            Tx_valid <= |sr[87:80];
          end
        end
        CR: if (Tx_ready) begin
          state   <= LF;
          Tx_data <= 8'h0A;
        end
        LF: if (Tx_ready) begin
          state    <= IDLE;
          Tx_data  <= '0;
          Tx_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ast_trace_streamer.sv
// Directed bench for ast_trace_streamer: instance 0 with EOL, instance 1 without.
module tb_ast_trace_streamer;

  localparam logic [95:0] S_ADD  = 96'h414444202052332C2052353B;
  localparam logic [95:0] S_RST  = 96'h0000_0000_0000_0000_5253_5420;
  localparam logic [95:0] S_NOP  = 96'h4E4F50202020202020202020;
  localparam logic [95:0] S_ZERO = 96'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] ic0, ic1;
  logic        v0i, v1i, rdy0, rdy1;
  logic [7:0]  d0, d1;
  logic        tv0, tv1;
  logic [2:0]  lvl0, lvl1;
  logic [7:0]  ovf0, ovf1;
  logic        busy0, busy1;

  int vecs = 0;
  int errs = 0;
  logic [7:0] got [$];

  logic [7:0] exp_add [14] = '{8'h41, 8'h44, 8'h44, 8'h20, 8'h20, 8'h52, 8'h33,
                               8'h2C, 8'h20, 8'h52, 8'h35, 8'h3B, 8'h0D, 8'h0A};
  logic [7:0] exp_rst [6]  = '{8'h52, 8'h53, 8'h54, 8'h20, 8'h0D, 8'h0A};
  logic [7:0] exp_nop [12] = '{8'h4E, 8'h4F, 8'h50, 8'h20, 8'h20, 8'h20,
                               8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};

  always #5 clk = ~clk;

  ast_trace_streamer #(.DEPTH(4), .TRAIL_EOL(1'b1)) dut0 (
    .Clock_pin(clk), .Reset_pin(rst), .ICis(ic0), .ICis_valid(v0i),
    .Tx_data(d0), .Tx_valid(tv0), .Tx_ready(rdy0),
    .Fifo_level(lvl0), .Overflow_cnt(ovf0), .Busy(busy0));

  ast_trace_streamer #(.DEPTH(4), .TRAIL_EOL(1'b0)) dut1 (
    .Clock_pin(clk), .Reset_pin(rst), .ICis(ic1), .ICis_valid(v1i),
    .Tx_data(d1), .Tx_valid(tv1), .Tx_ready(rdy1),
    .Fifo_level(lvl1), .Overflow_cnt(ovf1), .Busy(busy1));

  task automatic push(input bit sel, input logic [95:0] v);
    if (sel) begin ic1 = v; v1i = 1'b1; end
    else     begin ic0 = v; v0i = 1'b1; end
    @(posedge clk); #1;
    v0i = 1'b0;
    v1i = 1'b0;
  endtask

  // Gathers handshaken bytes until n arrive, then watches 20 more cycles for strays.
  task automatic collect(input bit sel, input int n, input int budget,
                         output bit tmo, output logic busy_end, output int extra);
    logic v, r;
    logic [7:0] d;
    got.delete();
    tmo = 1'b1;
    busy_end = 1'bx;
    extra = 0;
    for (int c = 0; c < budget && tmo; c++) begin
      v = sel ? tv1 : tv0;
      r = sel ? rdy1 : rdy0;
      d = sel ? d1 : d0;
      @(posedge clk); #1;
      if (v && r) got.push_back(d);
      if (got.size() == n) begin
        tmo = 1'b0;
        busy_end = sel ? busy1 : busy0;
      end
    end
    if (!tmo) begin
      for (int c = 0; c < 20; c++) begin
        if (sel ? tv1 : tv0) extra++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (tv0 !== 1'b0)  begin errs++; $display("FAIL reset_tx_valid got %b exp 0", tv0); end
    vecs++; if (d0 !== 8'h00)  begin errs++; $display("FAIL reset_tx_data got %h exp 00", d0); end
    vecs++; if (lvl0 !== 3'd0) begin errs++; $display("FAIL reset_level got %0d exp 0", lvl0); end
    vecs++; if (ovf0 !== 8'd0) begin errs++; $display("FAIL reset_ovf got %0d exp 0", ovf0); end
    vecs++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errs++; $display("FAIL reset_busy got %b%b exp 00", busy0, busy1); end
    rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if (tv0 !== 1'b0 || tv1 !== 1'b0) begin errs++; $display("FAIL idle_tx_valid got %b%b exp 00", tv0, tv1); end
  endtask

  task automatic test_single_add;
    rdy0 = 1'b1;
    ic0 = S_ADD; v0i = 1'b1;
    @(posedge clk); #1;
    v0i = 1'b0;
    vecs++; if (lvl0 !== 3'd1) begin errs++; $display("FAIL add_level_e0 got %0d exp 1", lvl0); end
    vecs++; if (tv0 !== 1'b0)  begin errs++; $display("FAIL add_valid_e0 got %b exp 0", tv0); end
    @(posedge clk); #1;
    vecs++; if (tv0 !== 1'b0)  begin errs++; $display("FAIL add_valid_e1 got %b exp 0", tv0); end
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        vecs++; if (lvl0 !== 3'd0) begin errs++; $display("FAIL add_level_e2 got %0d exp 0", lvl0); end
      end
      vecs++;
      if (tv0 !== 1'b1 || d0 !== exp_add[k]) begin
        errs++; $display("FAIL add_byte%0d got v=%b %h exp v=1 %h", k, tv0, d0, exp_add[k]);
      end
    end
    @(posedge clk); #1;
    vecs++; if (tv0 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL add_end got v=%b busy=%b exp 0 0", tv0, busy0); end
  endtask

  task automatic test_short_rst;
    bit tmo; logic be; int extra;
    rdy0 = 1'b1;
    push(1'b0, S_RST);
    collect(1'b0, 6, 100, tmo, be, extra);
    vecs++; if (tmo) begin errs++; $display("FAIL rst_timeout got %0d bytes exp 6", got.size()); end
    for (int i = 0; i < 6 && !tmo; i++) begin
      vecs++; if (got[i] !== exp_rst[i]) begin errs++; $display("FAIL rst_byte%0d got %h exp %h", i, got[i], exp_rst[i]); end
    end
    vecs++; if (extra != 0) begin errs++; $display("FAIL rst_extra got %0d exp 0", extra); end
  endtask

  task automatic test_backpressure;
    logic [7:0] pat = 8'b1010_0011;
    logic v, r;
    logic [7:0] d;
    int c = 0;
    got.delete();
    push(1'b0, S_ADD);
    while (got.size() < 14 && c < 300) begin
      rdy0 = pat[7 - (c % 8)];
      v = tv0; r = rdy0; d = d0;
      @(posedge clk); #1;
      if (v && r) got.push_back(d);
      if (v && !r) begin
        vecs++;
        if (tv0 !== 1'b1 || d0 !== d) begin
          errs++; $display("FAIL bp_stall_c%0d got v=%b %h exp v=1 %h", c, tv0, d0, d);
        end
      end
      c++;
    end
    vecs++; if (got.size() != 14) begin errs++; $display("FAIL bp_count got %0d exp 14", got.size()); end
    for (int i = 0; i < 14 && i < got.size(); i++) begin
      vecs++; if (got[i] !== exp_add[i]) begin errs++; $display("FAIL bp_byte%0d got %h exp %h", i, got[i], exp_add[i]); end
    end
    rdy0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Edge 2 is the LOAD pop, so 5 pushes land and only edges 5,6 drop.
  task automatic test_overflow;
    rdy0 = 1'b0;
    ic0 = S_ADD; v0i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        vecs++; if (lvl0 !== 3'd4) begin errs++; $display("FAIL ovf_level_e4 got %0d exp 4", lvl0); end
      end
    end
    vecs++; if (lvl0 !== 3'd4) begin errs++; $display("FAIL ovf_level_e6 got %0d exp 4", lvl0); end
    vecs++; if (ovf0 !== 8'd2) begin errs++; $display("FAIL ovf_cnt7 got %0d exp 2", ovf0); end
    vecs++; if (tv0 !== 1'b1 || d0 !== 8'h41) begin errs++; $display("FAIL ovf_stall got v=%b %h exp v=1 41", tv0, d0); end
    repeat (300) @(posedge clk);
    #1;
    v0i = 1'b0;
    vecs++; if (ovf0 !== 8'd255) begin errs++; $display("FAIL ovf_sat got %0d exp 255", ovf0); end
    @(posedge clk); #1;
    vecs++; if (ovf0 !== 8'd255 || lvl0 !== 3'd4) begin errs++; $display("FAIL ovf_hold got cnt=%0d lvl=%0d exp 255 4", ovf0, lvl0); end
  endtask

  task automatic test_reset_mid_send;
    bit tmo; logic be; int extra;
    rdy0 = 1'b1;
    repeat (5) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    vecs++; if (tv0 !== 1'b0)  begin errs++; $display("FAIL mid_rst_valid got %b exp 0", tv0); end
    vecs++; if (lvl0 !== 3'd0) begin errs++; $display("FAIL mid_rst_level got %0d exp 0", lvl0); end
    vecs++; if (ovf0 !== 8'd0) begin errs++; $display("FAIL mid_rst_ovf got %0d exp 0", ovf0); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if (tv0 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL post_rst got v=%b busy=%b exp 0 0", tv0, busy0); end
    push(1'b0, S_RST);
    collect(1'b0, 6, 100, tmo, be, extra);
    vecs++; if (tmo) begin errs++; $display("FAIL post_rst_timeout got %0d bytes exp 6", got.size()); end
    for (int i = 0; i < 6 && !tmo; i++) begin
      vecs++; if (got[i] !== exp_rst[i]) begin errs++; $display("FAIL post_rst_byte%0d got %h exp %h", i, got[i], exp_rst[i]); end
    end
    vecs++; if (extra != 0) begin errs++; $display("FAIL post_rst_extra got %0d exp 0", extra); end
  endtask

  task automatic test_no_eol;
    bit tmo; logic be; int extra;
    rdy1 = 1'b1;
    push(1'b1, S_ZERO);
    push(1'b1, S_NOP);
    vecs++; if (busy1 !== 1'b1) begin errs++; $display("FAIL noeol_busy got %b exp 1", busy1); end
    collect(1'b1, 12, 200, tmo, be, extra);
    vecs++; if (tmo) begin errs++; $display("FAIL noeol_timeout got %0d bytes exp 12", got.size()); end
    for (int i = 0; i < 12 && !tmo; i++) begin
      vecs++; if (got[i] !== exp_nop[i]) begin errs++; $display("FAIL noeol_byte%0d got %h exp %h", i, got[i], exp_nop[i]); end
    end
    vecs++; if (be !== 1'b0) begin errs++; $display("FAIL noeol_busy_end got %b exp 0", be); end
    vecs++; if (extra != 0)  begin errs++; $display("FAIL noeol_extra got %0d exp 0", extra); end
  endtask

  initial begin
    rst = 1'b1;
    ic0 = '0; ic1 = '0;
    v0i = 1'b0; v1i = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    test_reset;
    test_single_add;
    test_short_rst;
    test_backpressure;
    test_overflow;
    test_reset_mid_send;
    test_no_eol;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
